// File: rtl/param_mode_counter_if.sv
// Control and status bundle for param_mode_counter; the master drives controls, the slave (counter) returns status.
interface param_mode_counter_if #(
    parameter int WIDTH      = 8,
    parameter int PRESCALE_W = 4
);
    logic                  en;
    logic                  dir;
    logic                  sat_mode;
    logic                  load;
    logic [WIDTH-1:0]      load_val;
    logic [PRESCALE_W-1:0] prescale;
    logic [WIDTH-1:0]      cmp_val;
    logic                  clear_flags;
    logic [WIDTH-1:0]      count;
    logic                  tc;
    logic                  match;
    logic                  ovf_sticky;

    modport master (
        output en, dir, sat_mode, load, load_val, prescale, cmp_val, clear_flags,
        input  count, tc, match, ovf_sticky
    );

    modport slave (
        input  en, dir, sat_mode, load, load_val, prescale, cmp_val, clear_flags,
        output count, tc, match, ovf_sticky
    );
endinterface

// File: rtl/param_mode_counter.sv
// Up/down wrap-or-saturate counter with prescaler, load, compare match and sticky overflow.
// Count/tc update on the step or load edge (no pipeline); no backpressure, steps are never stalled.
module param_mode_counter #(
    parameter int               WIDTH      = 8,
    parameter int               PRESCALE_W = 4,
    parameter logic [WIDTH-1:0] RESET_VAL  = '0
) (
    input  logic                clk,
    input  logic                rst,
    param_mode_counter_if.slave bus
);
    logic [WIDTH-1:0]      count_q, count_d;
    logic [PRESCALE_W-1:0] pre_cnt_q, pre_cnt_d;
    logic                  tc_q, tc_d;
    logic                  ovf_q, ovf_d;
    logic                  step;
    logic                  at_bound;

    always_comb begin
        // >= rather than == so lowering prescale mid-count steps at once instead of rolling over
        step      = bus.en && (pre_cnt_q >= bus.prescale);
        at_bound  = bus.dir ? (count_q == '1) : (count_q == '0);
        count_d   = count_q;
        pre_cnt_d = pre_cnt_q;
        tc_d      = 1'b0;
        ovf_d     = ovf_q & ~bus.clear_flags;

        if (bus.load) begin
            count_d   = bus.load_val;
            pre_cnt_d = '0;
        end else if (bus.en) begin
            if (step) begin
                pre_cnt_d = '0;
                if (at_bound) begin
                    tc_d = 1'b1;
                    if (!bus.sat_mode) begin
                        count_d = bus.dir ? '0 : '1;
                        ovf_d   = 1'b1;
                    end
                end else begin
                    count_d = bus.dir ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
                end
            end else begin
                pre_cnt_d = pre_cnt_q + PRESCALE_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q   <= RESET_VAL;
            pre_cnt_q <= '0;
            tc_q      <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            count_q   <= count_d;
            pre_cnt_q <= pre_cnt_d;
            tc_q      <= tc_d;
            ovf_q     <= ovf_d;
        end
    end

    assign bus.count      = count_q;
    assign bus.tc         = tc_q;
    assign bus.ovf_sticky = ovf_q;
    assign bus.match      = (count_q == bus.cmp_val);
endmodule

// File: tb/tb_param_mode_counter.sv
// Directed self-checking bench for param_mode_counter (WIDTH=8, PRESCALE_W=4).
module tb_param_mode_counter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    param_mode_counter_if #(.WIDTH(8), .PRESCALE_W(4)) bus ();

    param_mode_counter #(.WIDTH(8), .PRESCALE_W(4), .RESET_VAL(8'h00)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [7:0] exp_cnt;
        rst = 1'b1;
        repeat (2) tick();
        n_checks++; if (bus.count !== 8'h00) begin n_fail++; $display("FAIL reset_count: got %h want %h", bus.count, 8'h00); end
        n_checks++; if (bus.tc !== 1'b0) begin n_fail++; $display("FAIL reset_tc: got %b want 0", bus.tc); end
        n_checks++; if (bus.ovf_sticky !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", bus.ovf_sticky); end
        n_checks++; if (bus.match !== 1'b1) begin n_fail++; $display("FAIL reset_match: got %b want 1", bus.match); end
        rst = 1'b0;
        bus.en = 1'b1; bus.dir = 1'b1; bus.prescale = 4'd0;
        for (int i = 1; i <= 5; i++) begin
            tick();
            exp_cnt = 8'(i);
            n_checks++; if (bus.count !== exp_cnt || bus.tc !== 1'b0 || bus.ovf_sticky !== 1'b0) begin
                n_fail++; $display("FAIL basic_up[%0d]: got count=%h tc=%b ovf=%b want count=%h tc=0 ovf=0", i, bus.count, bus.tc, bus.ovf_sticky, exp_cnt);
            end
        end
        rst = 1'b1;
        #1;
        n_checks++; if (bus.count !== 8'h00) begin n_fail++; $display("FAIL async_reset: got %h want %h", bus.count, 8'h00); end
        #1 rst = 1'b0;
        tick();
        n_checks++; if (bus.count !== 8'h01) begin n_fail++; $display("FAIL resume_after_reset: got %h want %h", bus.count, 8'h01); end
        bus.en = 1'b0;
    endtask

    task automatic test_wrap();
        bus.dir = 1'b1; bus.sat_mode = 1'b0; bus.en = 1'b1;
        bus.load = 1'b1; bus.load_val = 8'hFE;
        tick();
        bus.load = 1'b0;
        n_checks++; if (bus.count !== 8'hFE || bus.tc !== 1'b0) begin n_fail++; $display("FAIL wrap_load: got count=%h tc=%b want FE/0", bus.count, bus.tc); end
        tick();
        n_checks++; if (bus.count !== 8'hFF || bus.tc !== 1'b0 || bus.ovf_sticky !== 1'b0) begin n_fail++; $display("FAIL wrap_up_ff: got count=%h tc=%b ovf=%b want FF/0/0", bus.count, bus.tc, bus.ovf_sticky); end
        tick();
        n_checks++; if (bus.count !== 8'h00 || bus.tc !== 1'b1 || bus.ovf_sticky !== 1'b1) begin n_fail++; $display("FAIL wrap_up_00: got count=%h tc=%b ovf=%b want 00/1/1", bus.count, bus.tc, bus.ovf_sticky); end
        tick();
        n_checks++; if (bus.count !== 8'h01 || bus.tc !== 1'b0 || bus.ovf_sticky !== 1'b1) begin n_fail++; $display("FAIL wrap_tc_pulse: got count=%h tc=%b ovf=%b want 01/0/1", bus.count, bus.tc, bus.ovf_sticky); end
        bus.load = 1'b1; bus.load_val = 8'h00;
        tick();
        bus.load = 1'b0; bus.dir = 1'b0;
        tick();
        n_checks++; if (bus.count !== 8'hFF || bus.tc !== 1'b1) begin n_fail++; $display("FAIL wrap_down: got count=%h tc=%b want FF/1", bus.count, bus.tc); end
        bus.en = 1'b0; bus.clear_flags = 1'b1;
        tick();
        bus.clear_flags = 1'b0;
        n_checks++; if (bus.ovf_sticky !== 1'b0 || bus.tc !== 1'b0) begin n_fail++; $display("FAIL clear_flags: got ovf=%b tc=%b want 0/0", bus.ovf_sticky, bus.tc); end
    endtask

    task automatic test_saturate();
        logic [7:0] exp_up [4] = '{8'hFE, 8'hFF, 8'hFF, 8'hFF};
        logic       tc_up  [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic       tc_dn  [3] = '{1'b0, 1'b1, 1'b1};
        bus.sat_mode = 1'b1; bus.dir = 1'b1;
        bus.load = 1'b1; bus.load_val = 8'hFD;
        tick();
        bus.load = 1'b0; bus.en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++; if (bus.count !== exp_up[i] || bus.tc !== tc_up[i] || bus.ovf_sticky !== 1'b0) begin
                n_fail++; $display("FAIL sat_up[%0d]: got count=%h tc=%b ovf=%b want %h/%b/0", i, bus.count, bus.tc, bus.ovf_sticky, exp_up[i], tc_up[i]);
            end
        end
        bus.en = 1'b0; bus.load = 1'b1; bus.load_val = 8'h01;
        tick();
        bus.load = 1'b0; bus.en = 1'b1; bus.dir = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++; if (bus.count !== 8'h00 || bus.tc !== tc_dn[i] || bus.ovf_sticky !== 1'b0) begin
                n_fail++; $display("FAIL sat_down[%0d]: got count=%h tc=%b ovf=%b want 00/%b/0", i, bus.count, bus.tc, bus.ovf_sticky, tc_dn[i]);
            end
        end
        bus.en = 1'b0; bus.sat_mode = 1'b0;
    endtask

    task automatic test_prescaler();
        logic [7:0] exp_cnt [8] = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 8'h01, 8'h01, 8'h02};
        bus.dir = 1'b1; bus.prescale = 4'd3;
        bus.load = 1'b1; bus.load_val = 8'h00;
        tick();
        bus.load = 1'b0; bus.en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            n_checks++; if (bus.count !== exp_cnt[i]) begin n_fail++; $display("FAIL prescale3[%0d]: got %h want %h", i, bus.count, exp_cnt[i]); end
        end
        repeat (2) tick();
        bus.en = 1'b0;
        repeat (5) tick();
        n_checks++; if (bus.count !== 8'h02) begin n_fail++; $display("FAIL en_hold: got %h want %h", bus.count, 8'h02); end
        bus.en = 1'b1;
        tick();
        n_checks++; if (bus.count !== 8'h02) begin n_fail++; $display("FAIL pre_hold_a: got %h want %h", bus.count, 8'h02); end
        tick();
        n_checks++; if (bus.count !== 8'h03) begin n_fail++; $display("FAIL pre_hold_b: got %h want %h", bus.count, 8'h03); end
        bus.prescale = 4'd7;
        repeat (5) tick();
        n_checks++; if (bus.count !== 8'h03) begin n_fail++; $display("FAIL prescale7_wait: got %h want %h", bus.count, 8'h03); end
        bus.prescale = 4'd1;
        tick();
        n_checks++; if (bus.count !== 8'h04) begin n_fail++; $display("FAIL prescale_drop: got %h want %h", bus.count, 8'h04); end
        bus.en = 1'b0; bus.prescale = 4'd0;
    endtask

    task automatic test_load_priority();
        bus.dir = 1'b1; bus.sat_mode = 1'b0; bus.cmp_val = 8'h80;
        bus.load = 1'b1; bus.load_val = 8'hFF;
        tick();
        n_checks++; if (bus.match !== 1'b0) begin n_fail++; $display("FAIL match_off: got %b want 0", bus.match); end
        bus.en = 1'b1; bus.load_val = 8'h80;
        tick();
        bus.load = 1'b0;
        n_checks++; if (bus.count !== 8'h80 || bus.tc !== 1'b0 || bus.ovf_sticky !== 1'b0) begin n_fail++; $display("FAIL load_priority: got count=%h tc=%b ovf=%b want 80/0/0", bus.count, bus.tc, bus.ovf_sticky); end
        n_checks++; if (bus.match !== 1'b1) begin n_fail++; $display("FAIL match_on: got %b want 1", bus.match); end
        tick();
        n_checks++; if (bus.count !== 8'h81 || bus.match !== 1'b0) begin n_fail++; $display("FAIL match_after_step: got count=%h match=%b want 81/0", bus.count, bus.match); end
        bus.en = 1'b0;
    endtask

    task automatic test_flag_race();
        bus.dir = 1'b1; bus.sat_mode = 1'b0;
        bus.load = 1'b1; bus.load_val = 8'hFF;
        tick();
        bus.load = 1'b0; bus.en = 1'b1; bus.clear_flags = 1'b1;
        tick();
        n_checks++; if (bus.count !== 8'h00 || bus.tc !== 1'b1 || bus.ovf_sticky !== 1'b1) begin n_fail++; $display("FAIL flag_race: got count=%h tc=%b ovf=%b want 00/1/1", bus.count, bus.tc, bus.ovf_sticky); end
        bus.en = 1'b0;
        tick();
        bus.clear_flags = 1'b0;
        n_checks++; if (bus.ovf_sticky !== 1'b0) begin n_fail++; $display("FAIL flag_clear_after: got %b want 0", bus.ovf_sticky); end
    endtask

    initial begin
        bus.en = 1'b0; bus.dir = 1'b1; bus.sat_mode = 1'b0; bus.load = 1'b0;
        bus.load_val = 8'h00; bus.prescale = 4'd0; bus.cmp_val = 8'h00; bus.clear_flags = 1'b0;
        test_reset();
        test_wrap();
        test_saturate();
        test_prescaler();
        test_load_priority();
        test_flag_race();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/param_mode_counter.md
Name: param_mode_counter

Overview:
Parametrised successor to the team's single-mode free-running counter. Adds configurable width, up/down direction, wrap or saturate mode, synchronous parallel load, a programmable clock-enable prescaler, a compare-match output and a sticky overflow flag. It sits inside the top-level tile wrapper and is driven from ui_in/uio_in fields. It feeds uo_out, and also serves as the timer primitive for later blocks.

Parameters:
WIDTH, 8, counter width in bits (2..32)
PRESCALE_W, 4, prescaler select width; step rate = clk / (prescale+1)
RESET_VAL, 0, count value loaded on reset (WIDTH bits)

Ports:
clk  input  1  clock, rising-edge
rst  input  1  asynchronous reset, active-high
en  input  1  count enable; gates prescaler and stepping
dir  input  1  1 = count up, 0 = count down
sat_mode  input  1  1 = saturate at boundary, 0 = wrap
load  input  1  synchronous parallel load strobe
load_val  input  WIDTH  value written on load
prescale  input  PRESCALE_W  step divider minus one
cmp_val  input  WIDTH  compare value for match
clear_flags  input  1  clears ovf_sticky
count  output  WIDTH  current count register
tc  output  1  terminal-count pulse, one cycle, registered
match  output  1  count == cmp_val, combinational from count register
ovf_sticky  output  1  set on any wrap event, held until cleared

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Reset values: count=RESET_VAL, internal pre_cnt=0, tc=0, ovf_sticky=0. match reflects RESET_VAL vs cmp_val.
- Reset mid-operation: all state returns to reset values immediately, without waiting for a clock edge. Counting resumes on the first edge after rst deasserts.
- Prescaler:
  - pre_cnt (PRESCALE_W bits) increments each cycle en=1 and holds when en=0.
  - A step fires in a cycle where en=1 and pre_cnt >= prescale; pre_cnt returns to 0 on that edge.
  - The >= comparison makes a downward change of prescale mid-count take effect on the next cycle, with no long stall.
  - prescale=0 means a step every enabled cycle.
- Priority per edge: rst > load > step.
- load: count<=load_val, pre_cnt<=0, tc<=0. Any step in the same cycle is discarded. The load takes effect regardless of en.
- Step, up, wrap mode: count<=count+1 modulo 2^WIDTH. If count was all-ones, then count<=0, tc<=1 and ovf_sticky<=1.
- Step, down, wrap mode: count<=count-1. If count was 0, then count<=all-ones, tc<=1 and ovf_sticky<=1.
- Step, saturate mode, at the boundary for the current dir (all-ones up, 0 down): count holds, tc<=1, ovf_sticky unchanged. Every further step attempted at the boundary pulses tc again.
- Step not at a boundary: tc<=0.
- tc is 0 on every cycle without a boundary step. It is therefore a one-cycle pulse aligned with the count update.
- dir and sat_mode are sampled only on step cycles. Changing them between steps is legal and never causes glitches.
- ovf_sticky:
  - set by wrap events only;
  - cleared by clear_flags on the clock edge;
  - a simultaneous set and clear leaves the flag set.
- match is purely combinational equality with no registering. Latency from count change to match is 0 cycles after the edge.
- Latency: count changes on the same edge as the qualifying step or load. There is no pipeline.
- Arithmetic is unsigned, WIDTH bits, with no carry out other than tc and ovf_sticky.

Test Plan:
- Reset and basic up (WIDTH=8): rst=1 for 2 cycles, then en=1, dir=1, prescale=0 -> count 0,1,2,... per cycle; tc=0 and ovf_sticky=0 until wrap. Assert rst asynchronously mid-count -> count=0 before the next edge.
- Wrap up/down: load 0xFE, dir=1 -> 0xFF, 0x00 with tc=1 for exactly the cycle count=0x00, and ovf_sticky=1. Then dir=0 from 0x00 -> 0xFF with tc=1. clear_flags asserted with no wrap -> ovf_sticky=0.
- Saturate: sat_mode=1, load 0xFD, dir=1 -> 0xFE, 0xFF, 0xFF, 0xFF, with tc=1 on each attempted step at 0xFF and ovf_sticky staying 0. dir=0 from 0x01 -> 0x00, then holds with tc pulses.
- Prescaler: prescale=3, en=1 -> count steps every 4th cycle. Deassert en for 5 cycles -> count and pre_cnt hold. Set prescale from 7 to 1 while pre_cnt=5 -> step on the next enabled cycle.
- Load priority: load=1 with load_val=0x80 in the same cycle as a step at 0xFF in wrap mode -> count=0x80, tc=0, ovf_sticky unchanged. Set cmp_val=0x80 -> match=1 in the cycle after the load edge and 0 after the next step.
- Flag race: a wrap event and clear_flags in the same cycle -> ovf_sticky=1. clear_flags on the following cycle -> ovf_sticky=0.
